// File: rtl/sv32_ptw_pkg.sv
// Shared types for the Sv32 page table walker: PTE layout, walker states and the
// combinational PTE classification used at each level of the walk.
package sv32_ptw_pkg;

  localparam int VPN_WIDTH = 20;
  localparam int PPN_WIDTH = 22;
  localparam int PA_WIDTH  = 34;
  localparam int PTE_WIDTH = 32;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_REQ,
    ST_L1_WAIT,
    ST_L0_REQ,
    ST_L0_WAIT,
    ST_RESP,
    ST_DRAIN
  } ptw_state_t;

  typedef enum logic [1:0] {
    CHK_FAULT,
    CHK_LEAF,
    CHK_PTR
  } pte_chk_t;

  // level=1 for the root table. A pointer is only legal at level 1, and a level-1
  // leaf must be 4MB aligned (ppn0 zero).
  function automatic pte_chk_t pte_check(input pte_t pte, input logic level);
    pte_chk_t res;
    if (!pte.v || (!pte.r && pte.w)) begin
      res = CHK_FAULT;
    end else if (pte.r || pte.x) begin
      res = (level && (pte.ppn0 != 10'd0)) ? CHK_FAULT : CHK_LEAF;
    end else begin
      res = level ? CHK_PTR : CHK_FAULT;
    end
    return res;
  endfunction

  function automatic logic [PA_WIDTH-1:0] pte_addr(input logic [PPN_WIDTH-1:0] ppn,
                                                   input logic [9:0]           idx);
    return {ppn, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sv32_ptw.sv
// Sv32 two-level hardware page table walker serving L1 TLB misses through a
// single-outstanding PTE read port.
module sv32_ptw
  import sv32_ptw_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [PPN_WIDTH-1:0] satp_ppn_i,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [VPN_WIDTH-1:0] req_vpn_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PA_WIDTH-1:0]  mem_req_pa_o,
  input  logic                 mem_resp_valid_i,
  input  logic [PTE_WIDTH-1:0] mem_resp_pte_i,
  input  logic                 mem_resp_error_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [PTE_WIDTH-1:0] resp_pte_o,
  output logic                 resp_superpage_o,
  output logic                 resp_page_fault_o,
  output logic                 resp_access_fault_o
);

  ptw_state_t           state_q, state_d;
  logic [9:0]           vpn0_q, vpn0_d;
  logic [PA_WIDTH-1:0]  pa_q, pa_d;
  logic [PTE_WIDTH-1:0] pte_q, pte_d;
  logic                 sp_q, sp_d;
  logic                 pf_q, pf_d;
  logic                 af_q, af_d;

  logic                 at_l1;
  pte_chk_t             chk;
  pte_t                 resp_pte;

  assign resp_pte = pte_t'(mem_resp_pte_i);
  assign at_l1    = (state_q == ST_L1_WAIT);
  assign chk      = pte_check(resp_pte, at_l1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      vpn0_q  <= '0;
      pa_q    <= '0;
      pte_q   <= '0;
      sp_q    <= 1'b0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vpn0_q  <= vpn0_d;
      pa_q    <= pa_d;
      pte_q   <= pte_d;
      sp_q    <= sp_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vpn0_d  = vpn0_q;
    pa_d    = pa_q;
    pte_d   = pte_q;
    sp_d    = sp_q;
    pf_d    = pf_q;
    af_d    = af_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!flush_i && req_valid_i) begin
          vpn0_d  = req_vpn_i[9:0];
          pa_d    = pte_addr(satp_ppn_i, req_vpn_i[19:10]);
          state_d = ST_L1_REQ;
        end
      end

      ST_L1_REQ, ST_L0_REQ: begin
        // An accepted read must still have its response swallowed.
        if (flush_i) begin
          state_d = mem_req_ready_i ? ST_DRAIN : ST_IDLE;
        end else if (mem_req_ready_i) begin
          state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
        end
      end

      ST_L1_WAIT, ST_L0_WAIT: begin
        if (flush_i) begin
          state_d = mem_resp_valid_i ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid_i) begin
          if (mem_resp_error_i) begin
            pte_d   = '0;
            sp_d    = 1'b0;
            pf_d    = 1'b0;
            af_d    = 1'b1;
            state_d = ST_RESP;
          end else begin
            unique case (chk)
              CHK_PTR: begin
                pa_d    = pte_addr(mem_resp_pte_i[31:10], vpn0_q);
                state_d = ST_L0_REQ;
              end
              CHK_LEAF: begin
                pte_d   = mem_resp_pte_i;
                sp_d    = at_l1;
                pf_d    = 1'b0;
                af_d    = 1'b0;
                state_d = ST_RESP;
              end
              default: begin
                pte_d   = mem_resp_pte_i;
                sp_d    = 1'b0;
                pf_d    = 1'b1;
                af_d    = 1'b0;
                state_d = ST_RESP;
              end
            endcase
          end
        end
      end

      ST_RESP: begin
        if (flush_i || resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (mem_resp_valid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o         = (state_q == ST_IDLE);
  assign mem_req_valid_o     = (state_q == ST_L1_REQ) || (state_q == ST_L0_REQ);
  assign mem_req_pa_o        = pa_q;
  assign resp_valid_o        = (state_q == ST_RESP);
  assign resp_pte_o          = pte_q;
  assign resp_superpage_o    = sp_q;
  assign resp_page_fault_o   = pf_q;
  assign resp_access_fault_o = af_q;

  // The read port allows one outstanding request, so data may only arrive while waiting.
  resp_in_wait_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_resp_valid_i |-> (state_q inside {ST_L1_WAIT, ST_L0_WAIT, ST_DRAIN}));

endmodule

// File: tb/tb_sv32_ptw.sv
// Self-checking bench for sv32_ptw: table-driven walks with a response scoreboard,
// plus hand-written backpressure, flush and reset sequences.
module tb_sv32_ptw;
  import sv32_ptw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] satp_ppn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [33:0] mem_req_pa;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_pte;
  logic        mem_resp_error;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pte;
  logic        resp_superpage;
  logic        resp_page_fault;
  logic        resp_access_fault;

  always #5 clk = ~clk;

  sv32_ptw dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .satp_ppn_i         (satp_ppn),
    .flush_i            (flush),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_vpn_i          (req_vpn),
    .mem_req_valid_o    (mem_req_valid),
    .mem_req_ready_i    (mem_req_ready),
    .mem_req_pa_o       (mem_req_pa),
    .mem_resp_valid_i   (mem_resp_valid),
    .mem_resp_pte_i     (mem_resp_pte),
    .mem_resp_error_i   (mem_resp_error),
    .resp_valid_o       (resp_valid),
    .resp_ready_i       (resp_ready),
    .resp_pte_o         (resp_pte),
    .resp_superpage_o   (resp_superpage),
    .resp_page_fault_o  (resp_page_fault),
    .resp_access_fault_o(resp_access_fault)
  );

  typedef struct {
    logic [21:0] satp;
    logic [19:0] vpn;
    logic [31:0] l1_pte;
    logic        l1_err;
    logic        two_level;
    logic [31:0] l0_pte;
    logic        l0_err;
    logic [33:0] pa_l1;
    logic [33:0] pa_l0;
    logic [31:0] e_pte;
    logic        e_sp;
    logic        e_pf;
    logic        e_af;
  } vec_t;

  typedef struct {
    logic [31:0] pte;
    logic        sp;
    logic        pf;
    logic        af;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mem_hs   = 0;
  int   resp_hs  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: responses are compared at the negedge before their handshake edge.
  always @(negedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) mem_hs++;
    if (rst_n && resp_valid && resp_ready && !flush) begin
      resp_hs++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got pte 0x%0h expected no response", resp_pte);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_pte", resp_pte, mon_e.pte);
        check("resp_superpage", resp_superpage, mon_e.sp);
        check("resp_page_fault", resp_page_fault, mon_e.pf);
        check("resp_access_fault", resp_access_fault, mon_e.af);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic send_req(input logic [21:0] satp, input logic [19:0] vpn);
    satp_ppn  = satp;
    req_vpn   = vpn;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("accept_latency", mem_req_valid, 1);
    check("req_ready_busy", req_ready, 0);
  endtask

  task automatic mem_serve(input string tag, input logic [33:0] pa, input logic [31:0] data,
                           input logic err, input int stall);
    for (int i = 0; i < 50 && !mem_req_valid; i++) tick();
    check({tag, "_valid"}, mem_req_valid, 1);
    check({tag, "_pa"}, mem_req_pa, pa);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_valid"}, mem_req_valid, 1);
      check({tag, "_stall_pa"}, mem_req_pa, pa);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_wait_no_req"}, mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_pte   = data;
    mem_resp_error = err;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    mem_resp_pte   = 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int l1_stall, input int resp_stall);
    exp_q.push_back('{v.e_pte, v.e_sp, v.e_pf, v.e_af});
    send_req(v.satp, v.vpn);
    mem_serve("l1_req", v.pa_l1, v.l1_pte, v.l1_err, l1_stall);
    if (v.two_level) begin
      check("l0_latency", mem_req_valid, 1);
      mem_serve("l0_req", v.pa_l0, v.l0_pte, v.l0_err, 0);
    end
    check("resp_latency", resp_valid, 1);
    check("no_req_in_resp", mem_req_valid, 0);
    for (int i = 0; i < resp_stall; i++) begin
      tick();
      check("resp_hold_valid", resp_valid, 1);
      check("resp_hold_pte", resp_pte, v.e_pte);
      check("resp_hold_pf", resp_page_fault, v.e_pf);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_done_valid", resp_valid, 0);
    check("resp_done_ready", req_ready, 1);
    $display("walk %0d: vpn=%05h l1=%08h l0=%08h -> pte=%08h sp=%0d pf=%0d af=%0d",
             idx, v.vpn, v.l1_pte, v.l0_pte, v.e_pte, v.e_sp, v.e_pf, v.e_af);
  endtask

  initial begin
    int mem0, resp0;
    //          satp      vpn        l1_pte        e1  2  l0_pte        e0  pa_l1          pa_l0          e_pte         sp pf af
    vecs[0]  = '{22'h10,    20'h12345, 32'h0000_8001, 0, 1, 32'h0004_00CF, 0, 34'h0_0001_0120, 34'h0_0002_0D14, 32'h0004_00CF, 0, 0, 0};
    vecs[1]  = '{22'h10,    20'h12345, 32'h2000_00CF, 0, 0, 32'h0,         0, 34'h0_0001_0120, 34'h0,          32'h2000_00CF, 1, 0, 0};
    vecs[2]  = '{22'h10,    20'h12345, 32'h2000_04CF, 0, 0, 32'h0,         0, 34'h0_0001_0120, 34'h0,          32'h2000_04CF, 0, 1, 0};
    vecs[3]  = '{22'h10,    20'h12345, 32'h0,         0, 0, 32'h0,         0, 34'h0_0001_0120, 34'h0,          32'h0,         0, 1, 0};
    vecs[4]  = '{22'h10,    20'h12345, 32'h0000_8001, 0, 1, 32'h0000_8001, 0, 34'h0_0001_0120, 34'h0_0002_0D14, 32'h0000_8001, 0, 1, 0};
    vecs[5]  = '{22'h10,    20'h12345, 32'h0000_0005, 0, 0, 32'h0,         0, 34'h0_0001_0120, 34'h0,          32'h0000_0005, 0, 1, 0};
    vecs[6]  = '{22'h10,    20'h12345, 32'h0000_8001, 0, 1, 32'h1234_5678, 1, 34'h0_0001_0120, 34'h0_0002_0D14, 32'h0,         0, 0, 1};
    vecs[7]  = '{22'h10,    20'h12345, 32'h0000_00CF, 1, 0, 32'h0,         0, 34'h0_0001_0120, 34'h0,          32'h0,         0, 0, 1};
    vecs[8]  = '{22'h3ABCD, 20'hFFFFF, 32'hFFFF_FC01, 0, 1, 32'h0000_000B, 0, 34'h0_3ABC_DFFC, 34'h3_FFFF_FFFC, 32'h0000_000B, 0, 0, 0};
    vecs[9]  = '{22'h10,    20'h12345, 32'h0000_8001, 0, 1, 32'h0000_0045, 0, 34'h0_0001_0120, 34'h0_0002_0D14, 32'h0000_0045, 0, 1, 0};
    vecs[10] = '{22'h21,    20'h00400, 32'h0040_0009, 0, 0, 32'h0,         0, 34'h0_0002_1004, 34'h0,          32'h0040_0009, 1, 0, 0};

    rst_n = 1'b0; satp_ppn = '0; flush = 1'b0; req_valid = 1'b0; req_vpn = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_pte = '0; mem_resp_error = 1'b0;
    resp_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_pa", mem_req_pa, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_pte", resp_pte, 0);
    check("rst_resp_flags", {resp_superpage, resp_page_fault, resp_access_fault}, 0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i], 0, 0);

    // Backpressure on both the read port and the response.
    mem0 = mem_hs; resp0 = resp_hs;
    run_vec(11, vecs[0], 5, 3);
    check("bp_mem_handshakes", mem_hs - mem0, 2);
    check("bp_resp_handshakes", resp_hs - resp0, 1);

    // Flush while waiting for the L1 read: response swallowed by DRAIN.
    resp0 = resp_hs;
    send_req(22'h10, 20'h12345);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_req_ready", req_ready, 0);
    tick(); tick();
    check("drain_no_resp", resp_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_pte = 32'h2000_00CF;
    tick();
    mem_resp_valid = 1'b0;
    check("drain_exit_ready", req_ready, 1);
    check("drain_exit_resp", resp_valid, 0);
    tick();
    check("drain_resp_count", resp_hs - resp0, 0);
    $display("flush in L1_WAIT: drained");
    run_vec(12, vecs[0], 0, 0);

    // Flush in L1_REQ without handshake goes straight to IDLE.
    send_req(22'h10, 20'h12345);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_req_idle", req_ready, 1);
    check("flush_req_no_valid", mem_req_valid, 0);
    $display("flush in L1_REQ: idle");

    // Flush in L0_REQ coincident with a handshake still needs a drain.
    send_req(22'h10, 20'h12345);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_pte = 32'h0000_8001; tick(); mem_resp_valid = 1'b0;
    check("flush_l0_pa", mem_req_pa, 34'h0_0002_0D14);
    flush = 1'b1; mem_req_ready = 1'b1;
    tick();
    flush = 1'b0; mem_req_ready = 1'b0;
    check("flush_hs_drain", req_ready, 0);
    check("flush_hs_no_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    check("flush_hs_exit", req_ready, 1);
    $display("flush in L0_REQ with handshake: drained");

    // Flush in RESP drops the result.
    resp0 = resp_hs;
    send_req(22'h10, 20'h12345);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_pte = 32'h2000_00CF; tick(); mem_resp_valid = 1'b0;
    check("flush_resp_pre", resp_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_resp_dropped", resp_valid, 0);
    check("flush_resp_idle", req_ready, 1);
    check("flush_resp_count", resp_hs - resp0, 0);
    $display("flush in RESP: dropped");

    // Flush beats a request in IDLE.
    satp_ppn = 22'h10; req_vpn = 20'h12345; req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_no_walk", mem_req_valid, 0);
    check("flush_idle_ready", req_ready, 1);
    $display("flush with req in IDLE: ignored");

    // Asynchronous reset mid-walk.
    send_req(22'h10, 20'h12345);
    rst_n = 1'b0;
    #1;
    check("arst_mem_req_valid", mem_req_valid, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_pa", mem_req_pa, 0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("async reset mid-walk: idle");
    run_vec(13, vecs[1], 0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
